adder_inverse_pipe: RTL and testbench
=====================================

# adder_inverse_pipe

Pipelined inverse of the registered benchmark adder: given a WIDTH+1-bit sum and one WIDTH-bit operand b, recovers the other operand a = sum − b. The borrow chain is split into CHUNK-bit segments, one pipeline stage each, with valid/ready handshakes on both sides. It sits downstream of the adder benchmarks in the arithmetic generated-circuit set, as a checker and decoder of adder results, and as a width-scalable sequential benchmark of its own.

## Interface
Parameters:
- WIDTH, 89, operand width; sum input is WIDTH+1 bits.
- CHUNK, 32, borrow-chain segment width per pipeline stage; 1 ≤ CHUNK ≤ WIDTH+1.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sum_in/b_in valid.
- in_ready  output  1  block can accept this cycle.
- sum_in  input  WIDTH+1  adder result.
- b_in  input  WIDTH  known operand.
- out_valid  output  1  a_out/range_err valid.
- out_ready  input  1  downstream accepts.
- a_out  output  WIDTH  recovered operand, low WIDTH bits of sum_in − b_in.
- range_err  output  1  the pair is not a valid adder result.

## Operation
- N = ceil((WIDTH+1)/CHUNK) stages. Stage k subtracts chunk k (bits k·CHUNK upward) using the registered borrow from stage k−1. The stage-0 borrow-in is 0. b is zero-extended to WIDTH+1 bits. The last chunk may be narrower than CHUNK.
- Each stage has a valid bit. Unprocessed upper chunks ride forward. Finished lower chunks are delayed so that all bits of a result emerge together.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. When advance is 0, every stage register holds its value.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- range_err = final borrow-out (sum_in < b_in) OR difference bit WIDTH is set (a ≥ 2^WIDTH). a_out is the low WIDTH bits of the difference regardless of range_err.
- Results leave in acceptance order. No drops, no duplicates.
- Reset: all stage valid bits clear. out_valid=0, a_out=0, range_err=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation discards every in-flight result; none of them is ever presented.
- in_ready depends combinationally on out_ready. There is no other input-to-output combinational path.

## Timing
- Latency: an input accepted at edge t is presented (out_valid=1) after edge t+N, provided there is no stall. For the defaults, N=3.
- Throughput: one result per cycle while out_ready=1.
- With a simultaneous transfer in and out at the same edge, the pipeline shifts by one with no bubble.
- While out_valid=1 and out_ready=0, a_out and range_err stay stable until the transfer.

## Configuration
- ADDER_INVERSE_RANGE_CHECK_EN defined: range_err is computed as above. The final borrow and bit WIDTH are carried through the pipeline.
- Not defined: range_err is tied to 0 and the overflow/borrow logic is omitted. a_out and the timing are unchanged.

## Structure
- Shared package adder_inverse_pkg holds:
  - CHUNK default constant;
  - a function computing N from WIDTH and CHUNK;
  - a function giving the width of chunk k.
- One sub-module, adder_inverse_chunk: a registered CHUNK-bit subtract-with-borrow stage with a hold enable. It has ports for the chunk width, the operands, borrow_in, diff and borrow_out. It is instantiated N times by a generate loop.

## Test plan
- Basic subtraction: sum_in=10, b_in=3 → a_out=7, range_err=0, out_valid exactly 3 cycles after acceptance.
- Chunk-boundary borrow: sum_in=2^32, b_in=1 → a_out=0xFFFF_FFFF, range_err=0.
- Out-of-range cases:
  - sum_in=0, b_in=1 → a_out=2^89−1, range_err=1.
  - sum_in=2^89+5, b_in=3 → a_out=2, range_err=1.
  - Without the macro, both cases give range_err=0.
- Back-pressure: stream 6 random pairs with out_ready low for cycles 4–8. in_ready must be low whenever out_valid && !out_ready. All 6 results must be correct and in order, with none lost or repeated.
- Reset mid-stream: accept 2 inputs, assert reset for 1 cycle → out_valid=0 next cycle, neither result ever appears, in_ready=1 after release.
- Full-rate stream: 100 back-to-back random pairs with out_ready=1 → 100 consecutive out_valid cycles matching the reference model a = (sum − b) mod 2^89.

Source files
------------

// File: rtl/adder_inverse_pkg.sv
// adder_inverse_pkg: shared constants and sizing helpers for the
// pipelined adder inverse (a = sum - b).
package adder_inverse_pkg;

  localparam int CHUNK_DEF = 32;

  // Number of borrow-chain segments covering the WIDTH+1-bit sum.
  function automatic int num_stages(input int width, input int chunk);
    return (width + 1 + chunk - 1) / chunk;
  endfunction

  // Width of segment k; the top segment may be narrower than chunk.
  function automatic int chunk_width(input int width, input int chunk, input int k);
    int rem;
    rem = width + 1 - k * chunk;
    return (rem < chunk) ? rem : chunk;
  endfunction

endpackage

// File: rtl/adder_inverse_chunk.sv
// adder_inverse_chunk: one registered subtract-with-borrow segment.
// Holds its result while en is low.
module adder_inverse_chunk #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CW-1:0] sum_chunk,
  input  logic [CW-1:0] b_chunk,
  input  logic          borrow_in,
  output logic [CW-1:0] diff,
  output logic          borrow_out
);

  // The extra top bit of the CW+1-bit difference is the borrow out.
  logic [CW:0] res_d;
  assign res_d = {1'b0, sum_chunk} - {1'b0, b_chunk} - {{CW{1'b0}}, borrow_in};

  // Register the segment difference and its borrow when the pipe advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (en) begin
      diff       <= res_d[CW-1:0];
      borrow_out <= res_d[CW];
    end
  end

endmodule

// File: rtl/adder_inverse_pipe.sv
// adder_inverse_pipe: pipelined a = sum - b with valid/ready on both sides.
// An input register is followed by one stage per CHUNK-bit borrow segment,
// so latency is num_stages() cycles after acceptance.
// Optional: define ADDER_INVERSE_RANGE_CHECK_EN to drive range_err from the
// final borrow and difference bit WIDTH; otherwise range_err is tied to 0.
module adder_inverse_pipe
  import adder_inverse_pkg::*;
#(
  parameter int WIDTH = 89,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             range_err
);

  localparam int N = num_stages(WIDTH, CHUNK);

  logic           advance;
  logic [N:0]     vld_pipe;
  logic [N:0]     bor;       // bor[k] is the registered borrow into segment k
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] diff_all;  // all segments aligned at the output stage

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[N];
  assign b_ext     = {1'b0, b_in};
  assign bor[0]    = 1'b0;

  // Stage valid bits shift together; a stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[N-1:0], in_valid};
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int CW  = chunk_width(WIDTH, CHUNK, k);
    localparam int DLY = N - 1 - k;

    logic [k:0][CW-1:0] sum_q, b_q;
    logic [CW-1:0]      diff_k;

    // Upper operand chunks ride forward until their borrow arrives.
    always_ff @(posedge clk) begin
      if (reset) begin
        sum_q <= '0;
        b_q   <= '0;
      end else if (advance) begin
        sum_q[0] <= sum_in[LO +: CW];
        b_q[0]   <= b_ext[LO +: CW];
        for (int m = 1; m <= k; m++) begin
          sum_q[m] <= sum_q[m-1];
          b_q[m]   <= b_q[m-1];
        end
      end
    end

    adder_inverse_chunk #(.CW(CW)) u_chunk (
      .clk        (clk),
      .reset      (reset),
      .en         (advance),
      .sum_chunk  (sum_q[k]),
      .b_chunk    (b_q[k]),
      .borrow_in  (bor[k]),
      .diff       (diff_k),
      .borrow_out (bor[k+1])
    );

    if (DLY > 0) begin : g_dly
      logic [DLY-1:0][CW-1:0] dly_q;
      // Finished low segments wait for the top segment to complete.
      always_ff @(posedge clk) begin
        if (reset) dly_q <= '0;
        else if (advance) begin
          dly_q[0] <= diff_k;
          for (int m = 1; m < DLY; m++) dly_q[m] <= dly_q[m-1];
        end
      end
      assign diff_all[LO +: CW] = dly_q[DLY-1];
    end else begin : g_nodly
      assign diff_all[LO +: CW] = diff_k;
    end
  end

  assign a_out = diff_all[WIDTH-1:0];

`ifdef ADDER_INVERSE_RANGE_CHECK_EN
  // Invalid pair: sum < b (final borrow) or a does not fit in WIDTH bits.
  assign range_err = bor[N] | diff_all[WIDTH];
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_inverse_pipe.sv
// tb_adder_inverse_pipe: scoreboard bench for adder_inverse_pipe (defaults).
module tb_adder_inverse_pipe;

  localparam int W = 89;
`ifdef ADDER_INVERSE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   sum_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_out;
  logic         range_err;

  int   nchk = 0, nfail = 0, nout = 0, run = 0;
  exp_t sbq[$];
  bit   stalled = 1'b0;
  logic [W-1:0] hold_a;
  logic         hold_e;

  adder_inverse_pipe #(.WIDTH(W), .CHUNK(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W:0] s, input logic [W-1:0] b);
    logic [W+1:0] d;
    exp_t r;
    d     = {1'b0, s} - {2'b00, b};
    r.a   = d[W-1:0];
    r.err = RC & (d[W+1] | d[W]);
    return r;
  endfunction

  function automatic logic [W:0] rnd90();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W:0];
  endfunction

  // Output side: scoreboard pop, stall invariants, run length of outputs.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stalled = 1'b0;
      run     = 0;
    end else begin
      if (stalled && out_valid) begin
        chk("hold_a", a_out, hold_a);
        chk("hold_err", range_err, hold_e);
      end
      if (out_valid && !out_ready) chk("inrdy_stall", in_ready, 0);
      stalled = out_valid && !out_ready;
      hold_a  = a_out;
      hold_e  = range_err;
      if (out_valid && out_ready) begin
        nout++;
        run++;
        if (sbq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("a_out", a_out, e.a);
          chk("range_err", range_err, e.err);
        end
      end else run = 0;
    end
  end

  // Present one pair until accepted; push its expectation at acceptance.
  task automatic send(input logic [W:0] s, input logic [W-1:0] b, input exp_t e, input bit push);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    sum_in   = s;
    b_in     = b;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && push) sbq.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, n0, n, idx;
    bit acc;
    logic [W:0]   s6[6];
    logic [W-1:0] b6[6];
    logic [W:0]   s;
    logic [W-1:0] b;

    // reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // basic subtraction and latency
    send(90'd10, 89'd3, exp_t'{a: 89'd7, err: 1'b0}, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    drain();

    // chunk-boundary borrows and out-of-range pairs
    send(90'd1 << 32, 89'd1, exp_t'{a: 89'hFFFF_FFFF, err: 1'b0}, 1'b1);
    send(90'd1 << 64, 89'd1, exp_t'{a: 89'hFFFF_FFFF_FFFF_FFFF, err: 1'b0}, 1'b1);
    send(90'd0, 89'd1, exp_t'{a: {W{1'b1}}, err: RC}, 1'b1);
    send((90'd1 << 89) + 90'd5, 89'd3, exp_t'{a: 89'd2, err: RC}, 1'b1);
    in_valid = 1'b0;
    drain();

    // back-pressure: out_ready low for cycles 4..8
    for (int i = 0; i < 6; i++) begin
      b6[i] = rnd90();
      s6[i] = {1'b0, rnd90() >> 1} + {1'b0, b6[i]};
    end
    n0  = nout;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        sum_in = s6[idx];
        b_in   = b6[idx];
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sbq.push_back(model(s6[idx], b6[idx]));
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepted", idx, 6);
    drain();
    chk("bp_count", nout - n0, 6);

    // reset mid-stream discards both in-flight results
    send(90'h123, 89'h23, '0, 1'b0);
    send(90'h456, 89'h56, '0, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    n0 = nout;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_out", nout - n0, 0);

    // full-rate stream of 100 pairs
    n0 = nout;
    for (int i = 0; i < 100; i++) begin
      b = rnd90();
      if (i % 2 == 0) s = {1'b0, rnd90() >> 1} + {1'b0, b};
      else s = rnd90();
      send(s, b, model(s, b), 1'b1);
    end
    in_valid = 1'b0;
    n = 0;
    while (nout - n0 < 100 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("fr_count", nout - n0, 100);
    chk("fr_back_to_back", run >= 100, 1);
    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
